// File: rtl/period_meter_if.sv
// Measurement bus of the clk_in period meter.
// master drives clk_in/enable, slave is the meter itself.
interface period_meter_if #(
    parameter int WIDTH = 32
);
    logic             clk_in;
    logic             enable;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             meas_valid;
    logic             timeout;
    logic [15:0]      meas_count;
    logic             busy;

    modport master (
        output clk_in,
        output enable,
        input  period,
        input  high_time,
        input  meas_valid,
        input  timeout,
        input  meas_count,
        input  busy
    );

    modport slave (
        input  clk_in,
        input  enable,
        output period,
        output high_time,
        output meas_valid,
        output timeout,
        output meas_count,
        output busy
    );
endinterface

// File: rtl/period_meter.sv
// Period / high-time meter for an asynchronous divided clock.
// Counts sysclk cycles between synchronized clk_in edges.
module period_meter #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input logic           sysclk,
    input logic           rst,
    period_meter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic                   sync_s;
    logic                   rise;
    logic                   fall;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [15:0]      meas_count_q, meas_count_d;

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign rise   = sync_s & ~s_d_q;
    assign fall   = ~sync_s & s_d_q;

    // clk_in synchronizer plus one delayed copy for edge detection
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.clk_in};
            s_d_q  <= sync_s;
        end
    end

    // next state: counter, captures and flags
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        period_d     = period_q;
        high_d       = high_q;
        valid_d      = 1'b0;
        timeout_d    = timeout_q;
        meas_count_d = meas_count_q;
        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            hi_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
                ARM: begin
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = ONE;
                    end else if (cnt_q == TMO) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                MEASURE: begin
                    // a rise on the timeout cycle still ends a measurement
                    if (rise) begin
                        period_d     = cnt_q;
                        high_d       = hi_q;
                        valid_d      = 1'b1;
                        meas_count_d = meas_count_q + 16'd1;
                        timeout_d    = 1'b0;
                        cnt_d        = ONE;
                    end else if (cnt_q == TMO) begin
                        timeout_d = 1'b1;
                        state_d   = ARM;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                        if (fall) begin
                            hi_d = cnt_q;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    hi_d    = '0;
                end
            endcase
        end
    end

    // state and result registers
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hi_q         <= '0;
            period_q     <= '0;
            high_q       <= '0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
            meas_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            period_q     <= period_d;
            high_q       <= high_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
            meas_count_q <= meas_count_d;
        end
    end

    assign bus.period     = period_q;
    assign bus.high_time  = high_q;
    assign bus.meas_valid = valid_q;
    assign bus.timeout    = timeout_q;
    assign bus.meas_count = meas_count_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: vector table, scoreboard queue
// and hand sequences for timeout, disable, reset and wrap.
module tb_period_meter;

    localparam int W   = 16;
    localparam int TMO = 16;

    logic sysclk = 1'b0;
    logic rst    = 1'b1;

    period_meter_if #(.WIDTH(W)) bus ();

    period_meter #(
        .WIDTH      (W),
        .SYNC_STAGES(2),
        .TIMEOUT    (TMO)
    ) dut (
        .sysclk(sysclk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [W-1:0] period;
        logic [W-1:0] high;
        logic [15:0]  count;
        int           gap;
    } exp_t;

    typedef struct {
        int hi;
        int lo;
        int n;
        int exp_p;
        int exp_h;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        vecs[7];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_count = 16'd0;
    int          cyc = 0;
    int          last_valid_cyc = 0;
    logic        prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, act, req, $time);
        end
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(negedge sysclk);
            bus.clk_in = v;
        end
    endtask

    task automatic push(input int p, input int h, input int gap);
        exp_t e;
        exp_count = exp_count + 16'd1;
        e.period  = W'(p);
        e.high    = W'(h);
        e.count   = exp_count;
        e.gap     = gap;
        sb.push_back(e);
    endtask

    task automatic run_burst(input int hi, input int lo, input int n,
                             input int p, input int h);
        for (int i = 0; i < n; i++) begin
            if (i > 0) push(p, h, (i > 1) ? p : 0);
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"}, 32'(bus.period), 32'd0);
        check({tag, "_high"}, 32'(bus.high_time), 32'd0);
        check({tag, "_valid"}, 32'(bus.meas_valid), 32'd0);
        check({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
        check({tag, "_count"}, 32'(bus.meas_count), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    always @(posedge sysclk) begin
        #1;
        cyc++;
        if (bus.meas_valid) begin
            check("no_consec_valid", 32'(prev_valid), 32'd0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: period %0d, nothing expected (t=%0t)",
                         bus.period, $time);
            end else begin
                mon_e = sb.pop_front();
                check("period", 32'(bus.period), 32'(mon_e.period));
                check("high_time", 32'(bus.high_time), 32'(mon_e.high));
                check("meas_count", 32'(bus.meas_count), 32'(mon_e.count));
                check("timeout_clr", 32'(bus.timeout), 32'd0);
                if (mon_e.gap > 0)
                    check("valid_gap", 32'(cyc - last_valid_cyc), 32'(mon_e.gap));
            end
            last_valid_cyc = cyc;
        end
        prev_valid = bus.meas_valid;
    end

    initial begin
        #1000000;
        tests++;
        fails++;
        $display("FAIL watchdog: run exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        vecs[0] = '{3, 5, 5, 8, 3};
        vecs[1] = '{1, 1, 8, 2, 1};
        vecs[2] = '{2, 3, 4, 5, 2};
        vecs[3] = '{5, 5, 3, 10, 5};
        vecs[4] = '{1, 2, 4, 3, 1};
        vecs[5] = '{4, 6, 3, 10, 4};
        vecs[6] = '{8, 8, 3, 16, 8};

        bus.clk_in = 1'b0;
        bus.enable = 1'b0;
        repeat (3) @(negedge sysclk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge sysclk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        bus.enable = 1'b1;
        repeat (3) @(negedge sysclk);
        check("arm_busy", 32'(bus.busy), 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_burst(vecs[i].hi, vecs[i].lo, vecs[i].n,
                      vecs[i].exp_p, vecs[i].exp_h);
            drive(1'b0, 24);
            check("vec_drained", 32'(sb.size()), 32'd0);
            check("vec_timeout", 32'(bus.timeout), 32'd1);
            check("vec_busy", 32'(bus.busy), 32'd1);
        end

        // timeout timing, then two rises 10 apart
        @(negedge sysclk);
        rst = 1'b1;
        exp_count = 16'd0;
        @(negedge sysclk);
        rst = 1'b0;
        repeat (3) @(negedge sysclk);
        @(negedge sysclk);
        bus.clk_in = 1'b1;
        @(posedge sysclk);
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        bus.clk_in = 1'b0;
        repeat (15) @(posedge sysclk);
        #1;
        check("tmo_early", 32'(bus.timeout), 32'd0);
        @(posedge sysclk);
        #1;
        check("tmo_set", 32'(bus.timeout), 32'd1);
        check("tmo_busy", 32'(bus.busy), 32'd1);
        check("tmo_period", 32'(bus.period), 32'd0);
        drive(1'b1, 5);
        drive(1'b0, 5);
        push(10, 5, 0);
        @(negedge sysclk);
        bus.clk_in = 1'b1;
        @(posedge sysclk);
        @(posedge sysclk);
        #1;
        check("lat_early", 32'(bus.meas_valid), 32'd0);
        @(posedge sysclk);
        #1;
        check("lat_valid", 32'(bus.meas_valid), 32'd1);
        check("lat_tmo_clr", 32'(bus.timeout), 32'd0);
        drive(1'b1, 4);
        drive(1'b0, 24);
        check("tmo2_set", 32'(bus.timeout), 32'd1);
        check("tmo2_hold", 32'(bus.period), 32'd10);
        check("tmo2_drained", 32'(sb.size()), 32'd0);

        // enable dropped mid-measurement
        drive(1'b1, 3);
        drive(1'b0, 5);
        push(8, 3, 0);
        drive(1'b1, 3);
        drive(1'b0, 1);
        @(negedge sysclk);
        bus.enable = 1'b0;
        @(posedge sysclk);
        #1;
        check("dis_busy", 32'(bus.busy), 32'd0);
        check("dis_valid", 32'(bus.meas_valid), 32'd0);
        drive(1'b0, 4);
        drive(1'b1, 3);
        drive(1'b0, 5);
        check("dis_period", 32'(bus.period), 32'd8);
        check("dis_count", 32'(bus.meas_count), 32'(exp_count));
        @(negedge sysclk);
        bus.enable = 1'b1;
        drive(1'b0, 2);
        run_burst(3, 5, 3, 8, 3);
        drive(1'b0, 24);
        check("reen_drained", 32'(sb.size()), 32'd0);

        // reset pulsed mid-measurement at meas_count 5
        @(negedge sysclk);
        rst = 1'b1;
        @(negedge sysclk);
        rst = 1'b0;
        exp_count = 16'd0;
        repeat (2) @(negedge sysclk);
        run_burst(3, 5, 6, 8, 3);
        check("pre_rst_count", 32'(bus.meas_count), 32'd5);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        @(negedge sysclk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("midrst");
        @(negedge sysclk);
        rst = 1'b0;
        exp_count = 16'd0;
        run_burst(3, 5, 3, 8, 3);
        drive(1'b0, 24);
        check("post_rst_drained", 32'(sb.size()), 32'd0);
        check("post_rst_count", 32'(bus.meas_count), 32'd2);

        // meas_count wrap from a preloaded value
        @(negedge sysclk);
        bus.enable = 1'b0;
        drive(1'b0, 2);
        force dut.meas_count_q = 16'hFFFD;
        @(posedge sysclk);
        @(negedge sysclk);
        release dut.meas_count_q;
        exp_count = 16'hFFFD;
        @(negedge sysclk);
        check("preload", 32'(bus.meas_count), 32'h0000FFFD);
        bus.enable = 1'b1;
        drive(1'b0, 2);
        run_burst(2, 2, 4, 4, 2);
        drive(1'b0, 24);
        check("wrap_drained", 32'(sb.size()), 32'd0);
        check("wrap_count", 32'(bus.meas_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
